// File: rtl/mem_stage.sv
// Memory stage: issues data-memory requests and owns the MEM/WB pipeline register.
// Latency: non-memory op 1 cycle; memory op N+1 cycles for an ack after N BUSY cycles.
// Backpressure: MEM_stall holds upstream until ack or timeout; MEM_WB gets bubbles meanwhile.
module mem_stage #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] EX_MEM_PC_next,
  input  logic [15:0] EX_MEM_ALU_out,
  input  logic [17:0] EX_MEM_MEM_signals,
  input  logic [7:0]  EX_MEM_WB_signals,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        MEM_stall,
  output logic        MEM_err,
  output logic [15:0] MEM_WB_PC_next,
  output logic [15:0] MEM_WB_ALU_out,
  output logic [15:0] MEM_WB_MemData,
  output logic [7:0]  MEM_WB_WB_signals,
  output logic [15:0] MEM_WB_RegWriteData
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Last counter value before the access is force-completed.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] md_q, md_d;
  logic [7:0]  wb_q, wb_d;
  logic        stall_c;

  logic        mem_en;
  logic [15:0] mem_wdata_in;
  assign mem_en       = EX_MEM_MEM_signals[1];
  assign mem_wdata_in = EX_MEM_MEM_signals[17:2];

  // Next-state, request latching, MEM/WB load selection and stall generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    pc_d    = 16'h0;
    alu_d   = 16'h0;
    md_d    = 16'h0;
    wb_d    = 8'h0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          // Capture the request; MEM/WB receives a bubble this cycle.
          stall_c = 1'b1;
          wr_d    = EX_MEM_MEM_signals[0];
          addr_d  = EX_MEM_ALU_out;
          wdata_d = mem_wdata_in;
          cnt_d   = 8'h0;
          state_d = BUSY;
        end else begin
          pc_d  = EX_MEM_PC_next;
          alu_d = EX_MEM_ALU_out;
          wb_d  = EX_MEM_WB_signals;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // Instruction is still held in EX_MEM by the stall, so load it now.
          pc_d    = EX_MEM_PC_next;
          alu_d   = EX_MEM_ALU_out;
          wb_d    = EX_MEM_WB_signals;
          md_d    = wr_q ? 16'h0 : mem_rdata;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Force-complete as if acked, with no load data, and flag it.
          pc_d    = EX_MEM_PC_next;
          alu_d   = EX_MEM_ALU_out;
          wb_d    = EX_MEM_WB_signals;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request and MEM/WB registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'h0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      err_q   <= 1'b0;
      pc_q    <= 16'h0;
      alu_q   <= 16'h0;
      md_q    <= 16'h0;
      wb_q    <= 8'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      md_q    <= md_d;
      wb_q    <= wb_d;
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign MEM_stall = stall_c;
  assign MEM_err   = err_q;

  assign MEM_WB_PC_next    = pc_q;
  assign MEM_WB_ALU_out    = alu_q;
  assign MEM_WB_MemData    = md_q;
  assign MEM_WB_WB_signals = wb_q;
  // Write-back select: PCS picks the link PC, MemtoReg picks load data.
  assign MEM_WB_RegWriteData = wb_q[0] ? pc_q : (wb_q[2] ? md_q : alu_q);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4.
// Inputs driven 1 time unit after the rising edge, outputs sampled after settling.
// Expected values are hand-computed constants per scenario.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ex_pc, ex_alu;
  logic [17:0] ex_mem;
  logic [7:0]  ex_wb;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_wr, MEM_stall, MEM_err;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] wb_pc, wb_alu, wb_md, wb_rwd;
  logic [7:0]  wb_sig;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EX_MEM_PC_next      (ex_pc),
    .EX_MEM_ALU_out      (ex_alu),
    .EX_MEM_MEM_signals  (ex_mem),
    .EX_MEM_WB_signals   (ex_wb),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack),
    .mem_req             (mem_req),
    .mem_wr              (mem_wr),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .MEM_stall           (MEM_stall),
    .MEM_err             (MEM_err),
    .MEM_WB_PC_next      (wb_pc),
    .MEM_WB_ALU_out      (wb_alu),
    .MEM_WB_MemData      (wb_md),
    .MEM_WB_WB_signals   (wb_sig),
    .MEM_WB_RegWriteData (wb_rwd)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [15:0] pc, input logic [15:0] alu,
                        input logic [17:0] ms, input logic [7:0] wb);
    ex_pc  = pc;
    ex_alu = alu;
    ex_mem = ms;
    ex_wb  = wb;
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_wb"}, {8'h0, wb_sig}, 16'h0);
    check({tag, "_alu"}, wb_alu, 16'h0);
    check({tag, "_md"}, wb_md, 16'h0);
    check({tag, "_pc"}, wb_pc, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    set_ex(16'h0, 16'h0, 18'h0, 8'h0);
    tick();
    tick();
    // Reset state
    check("rst_req", {15'h0, mem_req}, 16'h0);
    check("rst_err", {15'h0, MEM_err}, 16'h0);
    check("rst_stall", {15'h0, MEM_stall}, 16'h0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_rwd", wb_rwd, 16'h0);
    check_bubble("rst");
    rst = 1'b0;

    // ADD passthrough: WB = {rd=3, RegWrite=1, MemtoReg=0, HLT=0, PCS=0}
    set_ex(16'h0101, 16'h1234, 18'h0, 8'h38);
    check("add_stall", {15'h0, MEM_stall}, 16'h0);
    tick();
    check("add_alu", wb_alu, 16'h1234);
    check("add_rwd", wb_rwd, 16'h1234);
    check("add_wb", {8'h0, wb_sig}, 16'h0038);
    check("add_pc", wb_pc, 16'h0101);
    check("add_stall2", {15'h0, MEM_stall}, 16'h0);

    // LW addr 0x0040, ack after 3 BUSY cycles; WB = {rd=5, RegWrite, MemtoReg}
    set_ex(16'h0102, 16'h0040, 18'h00002, 8'h5C);
    mem_rdata = 16'hBEEF;
    check("lw_stall0", {15'h0, MEM_stall}, 16'h1);
    check("lw_req0", {15'h0, mem_req}, 16'h0);
    tick();
    check("lw_req1", {15'h0, mem_req}, 16'h1);
    check("lw_addr1", mem_addr, 16'h0040);
    check("lw_wr1", {15'h0, mem_wr}, 16'h0);
    check("lw_stall1", {15'h0, MEM_stall}, 16'h1);
    check_bubble("lw_b1");
    tick();
    check("lw_req2", {15'h0, mem_req}, 16'h1);
    check("lw_stall2", {15'h0, MEM_stall}, 16'h1);
    check_bubble("lw_b2");
    tick();
    mem_ack = 1'b1;
    #1;
    check("lw_req3", {15'h0, mem_req}, 16'h1);
    check("lw_addr3", mem_addr, 16'h0040);
    check("lw_stall3", {15'h0, MEM_stall}, 16'h0);
    tick();
    mem_ack = 1'b0;
    check("lw_md", wb_md, 16'hBEEF);
    check("lw_rwd", wb_rwd, 16'hBEEF);
    check("lw_wb", {8'h0, wb_sig}, 16'h005C);
    check("lw_alu", wb_alu, 16'h0040);
    check("lw_req_done", {15'h0, mem_req}, 16'h0);

    // SW addr 0x0010 wdata 0xA5A5, immediate ack; WB = {rd=2, RegWrite=0}
    set_ex(16'h0103, 16'h0010, {16'hA5A5, 1'b1, 1'b1}, 8'h20);
    mem_rdata = 16'h1111;
    check("sw_stall0", {15'h0, MEM_stall}, 16'h1);
    tick();
    check("sw_req", {15'h0, mem_req}, 16'h1);
    check("sw_wr", {15'h0, mem_wr}, 16'h1);
    check("sw_wdata", mem_wdata, 16'hA5A5);
    check("sw_addr", mem_addr, 16'h0010);
    mem_ack = 1'b1;
    #1;
    check("sw_stall1", {15'h0, MEM_stall}, 16'h0);
    tick();
    mem_ack = 1'b0;
    check("sw_md", wb_md, 16'h0000);
    check("sw_regwrite", {15'h0, wb_sig[3]}, 16'h0);
    check("sw_rwd", wb_rwd, 16'h0010);
    check("sw_req_done", {15'h0, mem_req}, 16'h0);

    // LW with no ack: force-complete on the 4th BUSY cycle
    set_ex(16'h0104, 16'h0080, 18'h00002, 8'h5C);
    mem_rdata = 16'h9999;
    tick();
    tick();
    tick();
    tick();
    check("to_req4", {15'h0, mem_req}, 16'h1);
    check("to_stall4", {15'h0, MEM_stall}, 16'h0);
    check("to_err_pre", {15'h0, MEM_err}, 16'h0);
    tick();
    check("to_err", {15'h0, MEM_err}, 16'h1);
    check("to_md", wb_md, 16'h0000);
    check("to_wb", {8'h0, wb_sig}, 16'h005C);
    check("to_alu", wb_alu, 16'h0080);
    check("to_req_done", {15'h0, mem_req}, 16'h0);
    // Next instruction proceeds normally; error stays set
    set_ex(16'h0105, 16'h0777, 18'h0, 8'h38);
    check("to_next_stall", {15'h0, MEM_stall}, 16'h0);
    tick();
    check("to_next_alu", wb_alu, 16'h0777);
    check("to_err_sticky", {15'h0, MEM_err}, 16'h1);

    // Reset clears the error
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_err", {15'h0, MEM_err}, 16'h0);

    // Ack coincides with the timeout cycle: normal completion wins
    set_ex(16'h0106, 16'h00C0, 18'h00002, 8'h5C);
    mem_rdata = 16'hCAFE;
    tick();
    tick();
    tick();
    tick();
    mem_ack = 1'b1;
    #1;
    check("tack_stall", {15'h0, MEM_stall}, 16'h0);
    tick();
    mem_ack = 1'b0;
    check("tack_md", wb_md, 16'hCAFE);
    check("tack_rwd", wb_rwd, 16'hCAFE);
    check("tack_err", {15'h0, MEM_err}, 16'h0);

    // Reset during the second BUSY cycle abandons the request
    set_ex(16'h0107, 16'h0100, 18'h00002, 8'h5C);
    tick();
    check("rb_req1", {15'h0, mem_req}, 16'h1);
    tick();
    rst = 1'b1;
    tick();
    check("rb_req", {15'h0, mem_req}, 16'h0);
    check("rb_rwd", wb_rwd, 16'h0);
    check_bubble("rb");
    rst = 1'b0;
    // Stray ack in IDLE with a non-memory bubble presented
    set_ex(16'h0, 16'h0, 18'h0, 8'h0);
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    check("stray_stall", {15'h0, MEM_stall}, 16'h0);
    check("stray_req", {15'h0, mem_req}, 16'h0);
    tick();
    mem_ack = 1'b0;
    check("stray_md", wb_md, 16'h0);
    check("stray_req2", {15'h0, mem_req}, 16'h0);
    check("stray_err", {15'h0, MEM_err}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding the write-back stage. Consumes the EX/MEM bundle (ALU result, memory signals, write-back signals, next PC) and drives a variable-latency data-memory request/acknowledge interface. Stalls the front of the pipeline while an access is outstanding and owns the MEM/WB pipeline register, including the write-back data select.

## Interface
Parameters:
- TIMEOUT, 64: maximum BUSY cycles before an access is force-completed (valid range 2..255).

Ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- EX_MEM_PC_next  in  16  next PC of the instruction in MEM
- EX_MEM_ALU_out  in  16  ALU result; the memory address for LW/SW
- EX_MEM_MEM_signals  in  18  {MemWriteData[15:0], MemEnable, MemWrite}
- EX_MEM_WB_signals  in  8  {reg_rd[3:0], RegWrite, MemtoReg, HLT, PCS}
- mem_rdata  in  16  read data from data memory, valid when mem_ack=1
- mem_ack  in  1  data memory completes the current request this cycle
- mem_req  out  1  request valid; held high until acknowledged
- mem_wr  out  1  1 = write, 0 = read; stable while mem_req=1
- mem_addr  out  16  request address; stable while mem_req=1
- mem_wdata  out  16  write data; stable while mem_req=1
- MEM_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- MEM_err  out  1  sticky flag: an access timed out
- MEM_WB_PC_next  out  16  pipelined next PC
- MEM_WB_ALU_out  out  16  pipelined ALU result
- MEM_WB_MemData  out  16  pipelined load data
- MEM_WB_WB_signals  out  8  pipelined write-back signals, same packing as input
- MEM_WB_RegWriteData  out  16  combinational: PCS ? PC_next : MemtoReg ? MemData : ALU_out (all MEM_WB_ values)

## Operation
- FSM states: IDLE, BUSY.
- IDLE, MemEnable=0: the instruction passes through. MEM_WB loads the instruction's PC_next, ALU_out and WB_signals, and MemData=0. MEM_stall=0.
- IDLE, MemEnable=1: MEM_stall=1. Latch address (ALU_out), wdata (MemWriteData) and wr (MemWrite) into request registers. Clear the timeout counter. Go to BUSY. MEM_WB loads a bubble (all fields 0).
- BUSY: mem_req=1 and drives the latched values.
  - mem_ack=0: MEM_stall=1. Counter increments. MEM_WB loads a bubble.
  - mem_ack=1: MEM_stall=0. MEM_WB loads the instruction (held in EX_MEM by the stall), with MemData = mem_rdata for reads and 0 for writes. Return to IDLE.
- Timeout: counter reaches TIMEOUT-1 in BUSY with no ack. Force-complete exactly as an ack, with MemData=0. Set MEM_err. Return to IDLE. An ack arriving in the same cycle takes priority and MEM_err is not set.
- mem_ack while in IDLE is ignored.
- Back-to-back memory instructions: each one reenters BUSY through IDLE, so there are no overlapping requests.
- MEM_err clears only on reset.
- Bubble = RegWrite=0, HLT=0, all data fields 0. A bubble never writes a register or halts.

## Timing
- Reset: state=IDLE, counter=0. mem_req, mem_wr, mem_addr, mem_wdata, MEM_err and every MEM_WB_* output are 0. MEM_stall = 0 after reset unless EX_MEM presents MemEnable=1.
- Reset in BUSY: mem_req drops on the next edge and the request is abandoned. Data memory must tolerate an abandoned request.
- Non-memory instruction: 1 cycle EX_MEM to MEM_WB.
- Memory instruction, ack in the first BUSY cycle: 2 cycles, 1 stall cycle visible upstream.
- Ack after N BUSY cycles: N+1 cycles. Stall is high for N cycles. Stall is low in the ack cycle so that upstream advances on the same edge MEM_WB captures.
- Request signals change only on entry to BUSY.
- MEM_stall is combinational from state, MemEnable, mem_ack and the counter.

## Test plan
- ADD passthrough: ALU_out=0x1234, WB={4'h3,1,0,0,0}, MemEnable=0 -> next cycle MEM_WB_ALU_out=0x1234, RegWriteData=0x1234, MEM_stall never 1.
- LW, ack after 3 BUSY cycles with rdata=0xBEEF, addr 0x0040 -> mem_req high for 3 cycles with addr=0x0040, wr=0. MEM_stall high for cycles 0..2 (entry cycle plus the first 2 BUSY cycles) and low on the ack cycle. Bubbles in MEM_WB during the stall, then MemData=0xBEEF, RegWriteData=0xBEEF with MemtoReg=1.
- SW with immediate ack: addr=0x0010, wdata=0xA5A5 -> single req cycle with wr=1, wdata=0xA5A5. MEM_WB RegWrite=0, MemData=0.
- TIMEOUT=4, LW, no ack -> force-complete after 4 BUSY cycles, MEM_err=1 and stays 1, MemData=0. Next instruction proceeds normally.
- Ack in the same cycle as the timeout -> normal completion with rdata, MEM_err stays 0.
- rst asserted in the second BUSY cycle -> next cycle state IDLE, mem_req=0, all MEM_WB outputs 0. A stray ack afterwards is ignored.
